// File: rtl/qsic_dma_pkg.sv
// qsic_dma_pkg: shared state encoding, defaults and round-robin helpers for QSIC arbiters
package qsic_dma_pkg;
  typedef enum logic [2:0] {IDLE, REQ, ACK, MASTER, REL} dma_state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_BURST_MAX = 8;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
  function automatic int rr_first(input logic [7:0] req, input int ptr, input int n);
    for (int k = 0; k < n; k++)
      if (req[3'((ptr + k) % n)]) return (ptr + k) % n;
    return ptr;
  endfunction
endpackage

// File: rtl/qbus_sync2.sv
// qbus_sync2: two-flop synchronizer with asynchronous active-high reset
module qbus_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: Qbus DMR/DMG/SACK bus-master arbitration with round-robin engine selection
module dma_arbiter
  import qsic_dma_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int PTR_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic               xfer,
  output logic [NUM_REQ-1:0] gnt,
  output logic               yield,
  output logic               bus_master,
  output logic               bdmr_out,
  output logic               bsack_out,
  input  logic               bdmgi,
  output logic               bdmgo,
  input  logic               bsync_in,
  input  logic               brply_in
);
  localparam logic [7:0] BMAX = 8'(BURST_MAX);
  dma_state_t state;
  logic dmgi_s, sync_s, rply_s, passing;
  logic [PTR_W-1:0] ptr, win, pick, nxt;
  logic [7:0] cnt;
  qbus_sync2 u_dmgi (.clk(clk), .reset(reset), .d(bdmgi), .q(dmgi_s));
  qbus_sync2 u_sync (.clk(clk), .reset(reset), .d(bsync_in), .q(sync_s));
  qbus_sync2 u_rply (.clk(clk), .reset(reset), .d(brply_in), .q(rply_s));
  always_comb begin
    pick = PTR_W'(rr_first(8'(req), int'(ptr), NUM_REQ));
    nxt = PTR_W'(rr_next(int'(win), NUM_REQ));
    bdmr_out = state == REQ;
    bsack_out = state == ACK || state == MASTER;
    bus_master = |gnt;
    yield = cnt == BMAX;
    bdmgo = bdmgi && (passing || (state == IDLE && !(|req)));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      win <= '0;
      ptr <= '0;
      cnt <= '0;
      passing <= 1'b0;
    end else begin
      passing <= (state == IDLE && bdmgi) || (passing && dmgi_s);
      case (state)
        IDLE: if (|req) state <= REQ;
        REQ: if (dmgi_s && !passing) state <= ACK;
        ACK:
          if (!dmgi_s && !sync_s && !rply_s) begin
            if (|req) begin
              win <= pick;
              gnt <= NUM_REQ'(1) << pick;
              state <= MASTER;
            end else state <= REL;
          end
        MASTER:
          if (|(done & gnt)) begin
            gnt <= '0;
            ptr <= nxt;
            cnt <= '0;
            state <= REL;
          end else if (xfer && cnt != BMAX) cnt <= cnt + 8'd1;
        REL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed and randomized tenures checked against a round-robin reference model
module tb_dma_arbiter;
  localparam int N = 4;
  localparam int BM = 8;
  logic clk = 1'b0, reset = 1'b1, xfer = 1'b0, bdmgi = 1'b0, bsync_in = 1'b0, brply_in = 1'b0;
  logic [N-1:0] req = '0, done = '0, gnt;
  logic yield, bus_master, bdmr_out, bsack_out, bdmgo;
  int checks = 0, errors = 0, mptr = 0, w;
  int order [5] = '{0, 1, 2, 3, 0};
  dma_arbiter #(.NUM_REQ(N), .BURST_MAX(BM), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .xfer(xfer), .gnt(gnt), .yield(yield),
    .bus_master(bus_master), .bdmr_out(bdmr_out), .bsack_out(bsack_out), .bdmgi(bdmgi),
    .bdmgo(bdmgo), .bsync_in(bsync_in), .brply_in(brply_in)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[2'((mptr + k) % N)]) return (mptr + k) % N;
    return -1;
  endfunction
  task automatic wait_sack;
    int n = 0;
    while (!bsack_out && n < 8) begin
      tick(1);
      n++;
    end
    chk("sack_rise", bsack_out, 1);
  endtask
  task automatic wait_master;
    int n = 0;
    while (!bus_master && n < 8) begin
      tick(1);
      n++;
    end
    chk("master_rise", bus_master, 1);
  endtask
  task automatic grant_phase(input int ew, input int nx, input bit xd, input int hold);
    int c = 0;
    logic [N-1:0] m = N'(1) << ew;
    bdmgi = 1'b1;
    wait_sack();
    chk("ack_dmgo_blocked", bdmgo, 0);
    chk("ack_dmr_low", bdmr_out, 0);
    bsync_in = hold > 0;
    bdmgi = 1'b0;
    if (hold > 0) begin
      tick(4);
      chk("ack_waits_bsync", bus_master, 0);
      bsync_in = 1'b0;
    end
    wait_master();
    chk("gnt_winner", gnt, m);
    req = req & ~m;
    for (int i = 0; i < nx; i++) begin
      xfer = 1'b1;
      tick(1);
      xfer = 1'b0;
      c = c < BM ? c + 1 : BM;
      chk("yield", yield, c == BM);
    end
    done = ~m;
    tick(1);
    done = '0;
    chk("stray_done_ignored", gnt, m);
    done = m;
    xfer = xd;
    tick(1);
    done = '0;
    xfer = 1'b0;
    chk("rel_sack", bsack_out, 0);
    chk("rel_master", {bus_master, gnt}, 0);
    chk("rel_yield", yield, 0);
    tick(1);
    chk("idle_sack", bsack_out, 0);
    mptr = (ew + 1) % N;
  endtask
  task automatic tenure(input logic [N-1:0] mask, input int nx, input bit xd, input int hold, output int ew);
    req = mask;
    ew = model_pick(mask);
    tick(1);
    chk("dmr_latency", bdmr_out, 1);
    grant_phase(ew, nx, xd, hold);
  endtask
  initial begin
    tick(1);
    chk("reset_outs", {gnt, yield, bus_master, bdmr_out, bsack_out, bdmgo}, 0);
    reset = 1'b0;
    tick(1);
    bdmgi = 1'b1;
    #1 chk("pass_idle_rise", bdmgo, 1);
    tick(3);
    chk("pass_idle_hold", {bdmgo, bdmr_out, gnt}, 32'h20);
    bdmgi = 1'b0;
    #1 chk("pass_idle_fall", bdmgo, 0);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      tenure(4'b1111, 0, 1'b0, 0, w);
      chk("rr_order", w, order[i]);
    end
    tenure(4'b0010, 2, 1'b0, 0, w);
    chk("single_req_winner", w, 1);
    bdmgi = 1'b1;
    tick(3);
    req = 4'b0100;
    #1 chk("passing_req_rise", bdmgo, 1);
    tick(1);
    chk("passing_dmr", {bdmr_out, bdmgo}, 2'b11);
    tick(4);
    chk("passing_not_captured", {bsack_out, bdmgo}, 2'b01);
    bdmgi = 1'b0;
    #1 chk("passing_fall", bdmgo, 0);
    tick(4);
    chk("passing_done_no_sack", bsack_out, 0);
    bdmgi = 1'b1;
    #1 chk("second_dmg_blocked", bdmgo, 0);
    grant_phase(model_pick(req), 0, 1'b0, 0);
    tenure(4'b0001, 8, 1'b1, 0, w);
    tenure(4'b0001, 10, 1'b0, 1, w);
    tenure(4'b0001, 7, 1'b0, 0, w);
    req = 4'b1000;
    tick(1);
    bdmgi = 1'b1;
    wait_sack();
    bdmgi = 1'b0;
    wait_master();
    reset = 1'b1;
    req = '0;
    #1 chk("async_reset_outs", {gnt, bsack_out, bus_master, bdmr_out, yield}, 0);
    tick(2);
    reset = 1'b0;
    mptr = 0;
    tenure(4'b1111, 1, 1'b0, 0, w);
    chk("ptr_after_reset", w, 0);
    for (int i = 0; i < 20; i++)
      tenure(4'($urandom_range(1, 15)), $urandom_range(0, 10), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), w);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
